// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART receiver: register map, bit
// positions and receive FSM states.
package uart_pkg;

  localparam logic [1:0] REG_RXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned ST_NE_BIT   = 0;
  localparam int unsigned ST_FULL_BIT = 1;
  localparam int unsigned ST_OVR_BIT  = 2;
  localparam int unsigned ST_FE_BIT   = 3;
  localparam int unsigned ST_CNT_LSB  = 8;

  localparam int unsigned CTRL_EN_BIT    = 0;
  localparam int unsigned CTRL_IRQEN_BIT = 1;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/wb_uart_rx_if.sv
// Wishbone classic slave bus bundle used by the UART receiver register block.
interface wb_uart_rx_if;
  logic [3:0]  adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output adr, dat_w, sel, we, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, sel, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens
// in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_uart_rx.sv
// 16x-oversampling UART receiver (8N1) with RX FIFO, sticky error flags and
// a Wishbone classic register interface.
module wb_uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = 13,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        uart_rx,
  output logic        irq_o
);

  localparam int unsigned DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_uart_rx_if bus ();

  assign bus.adr   = wb_adr_i;
  assign bus.dat_w = wb_dat_i;
  assign bus.sel   = wb_sel_i;
  assign bus.we    = wb_we_i;
  assign bus.cyc   = wb_cyc_i;
  assign bus.stb   = wb_stb_i;
  assign wb_dat_o  = bus.dat_r;
  assign wb_ack_o  = bus.ack;

  logic unused_bits;
  assign unused_bits = ^{bus.adr[1:0], bus.sel[3:1], bus.dat_w[31:4]};

  logic rx_meta_q, rx_q;
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_q      <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_q      <= rx_meta_q;
    end
  end

  logic [DIV_W-1:0] div_q;
  logic             tick;
  assign tick = (div_q == DIV_W'(BAUD_DIV - 1));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) div_q <= '0;
    else           div_q <= tick ? '0 : div_q + DIV_W'(1);
  end

  logic en_q, irq_en_q;

  rx_state_e  state_q;
  logic [3:0] smp_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q;
  logic       push_q, fe_set_q;

  // Clearing en overrides every state so an in-flight frame is dropped silently.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q  <= RX_IDLE;
      smp_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      push_q   <= 1'b0;
      fe_set_q <= 1'b0;
    end else begin
      push_q   <= 1'b0;
      fe_set_q <= 1'b0;
      if (!en_q) begin
        state_q <= RX_IDLE;
      end else begin
        case (state_q)
          RX_IDLE: begin
            if (!rx_q) begin
              state_q <= RX_START;
              smp_q   <= '0;
            end
          end
          RX_START: begin
            if (tick) begin
              smp_q <= smp_q + 4'd1;
              if (smp_q == 4'd7) begin
                smp_q   <= '0;
                bit_q   <= '0;
                state_q <= rx_q ? RX_IDLE : RX_DATA;
              end
            end
          end
          RX_DATA: begin
            if (tick) begin
              smp_q <= smp_q + 4'd1;
              if (smp_q == 4'd15) begin
                shift_q <= {rx_q, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
                if (bit_q == 3'd7) state_q <= RX_STOP;
              end
            end
          end
          RX_STOP: begin
            if (tick) begin
              smp_q <= smp_q + 4'd1;
              if (smp_q == 4'd15) begin
                if (rx_q) begin
                  push_q  <= 1'b1;
                  state_q <= RX_IDLE;
                end else begin
                  fe_set_q <= 1'b1;
                  state_q  <= RX_BREAK;
                end
              end
            end
          end
          RX_BREAK: begin
            if (tick && rx_q) state_q <= RX_IDLE;
          end
          default: state_q <= RX_IDLE;
        endcase
      end
    end
  end

  logic             fifo_pop, fifo_full, fifo_empty;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_cnt;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk),
    .rst_ni  (wb_rst_n),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  logic        ack_q, pop_pend_q, ovr_q, fe_q, irq_q;
  logic [31:0] dat_q;
  logic        req, wr_ok, ovr_set, ovr_clr, fe_clr;
  logic [1:0]  reg_sel;
  logic [31:0] status_w, rd_data;

  assign req      = bus.cyc && bus.stb && !ack_q;
  assign reg_sel  = bus.adr[3:2];
  assign wr_ok    = req && bus.we && bus.sel[0];
  assign ovr_set  = push_q && fifo_full && !fifo_pop;
  assign ovr_clr  = wr_ok && (reg_sel == REG_STATUS) && bus.dat_w[ST_OVR_BIT];
  assign fe_clr   = wr_ok && (reg_sel == REG_STATUS) && bus.dat_w[ST_FE_BIT];
  assign fifo_pop = pop_pend_q;

  always_comb begin
    status_w                     = '0;
    status_w[ST_NE_BIT]          = !fifo_empty;
    status_w[ST_FULL_BIT]        = fifo_full;
    status_w[ST_OVR_BIT]         = ovr_q;
    status_w[ST_FE_BIT]          = fe_q;
    status_w[ST_CNT_LSB +: 8]    = 8'(fifo_cnt);
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_RXDATA: if (!fifo_empty) rd_data[7:0] = fifo_head;
      REG_STATUS: rd_data = status_w;
      REG_CTRL: begin
        rd_data[CTRL_EN_BIT]    = en_q;
        rd_data[CTRL_IRQEN_BIT] = irq_en_q;
      end
      REG_RSVD: rd_data = '0;
      default:  rd_data = '0;
    endcase
  end

  // Head is captured at request time; the pop itself lands in the ack cycle.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      pop_pend_q <= 1'b0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ack_q      <= req;
      dat_q      <= (req && !bus.we) ? rd_data : '0;
      pop_pend_q <= req && !bus.we && (reg_sel == REG_RXDATA) && !fifo_empty;
      if (wr_ok && (reg_sel == REG_CTRL)) begin
        en_q     <= bus.dat_w[CTRL_EN_BIT];
        irq_en_q <= bus.dat_w[CTRL_IRQEN_BIT];
      end
      ovr_q <= ovr_set  || (ovr_q && !ovr_clr);
      fe_q  <= fe_set_q || (fe_q && !fe_clr);
      irq_q <= irq_en_q && (!fifo_empty || ovr_q || fe_q);
    end
  end

  assign bus.dat_r = dat_q;
  assign bus.ack   = ack_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_uart_rx.sv
// Directed/randomized bench for wb_uart_rx against a byte-queue model of the
// receive path and register map.
module tb_wb_uart_rx;

  localparam int unsigned BIT = 16 * 13;

  logic clk, rst_n, uart_rx;
  logic irq;
  wb_uart_rx_if bus ();

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] mq [$];
  logic       m_ovr, m_fe;

  wb_uart_rx #(.BAUD_DIV(13), .FIFO_DEPTH(16)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .wb_adr_i (bus.adr),
    .wb_dat_i (bus.dat_w),
    .wb_sel_i (bus.sel),
    .wb_we_i  (bus.we),
    .wb_cyc_i (bus.cyc),
    .wb_stb_i (bus.stb),
    .wb_dat_o (bus.dat_r),
    .wb_ack_o (bus.ack),
    .uart_rx  (uart_rx),
    .irq_o    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0] = (mq.size() != 0);
    s[1] = (mq.size() == 16);
    s[2] = m_ovr;
    s[3] = m_fe;
    s[15:8] = 8'(mq.size());
    return s;
  endfunction

  task automatic wb_xfer(input logic we, input logic [3:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, output logic [31:0] rd);
    int unsigned n;
    @(negedge clk);
    bus.adr = adr; bus.dat_w = wd; bus.sel = sel; bus.we = we;
    bus.cyc = 1'b1; bus.stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ack && n < 8);
    rd = bus.dat_r;
    if (!bus.ack) begin
      checks++;
      errors++;
      $error("FAIL ack_timeout: observed ack=0 expected ack=1 at adr 0x%0h", adr);
    end
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] adr, output logic [31:0] d);
    wb_xfer(1'b0, adr, '0, 4'hF, d);
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, d, sel, dummy);
  endtask

  task automatic wait_bits(input int unsigned n);
    repeat (n * BIT) @(negedge clk);
  endtask

  // stop_low = 0 sends a valid stop bit, otherwise the line stays low that many bit times.
  task automatic send_frame(input logic [7:0] b, input int unsigned stop_low);
    uart_rx = 1'b0;
    wait_bits(1);
    for (int unsigned i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_bits(1);
    end
    if (stop_low != 0) begin
      uart_rx = 1'b0;
      wait_bits(stop_low);
      m_fe = 1'b1;
    end else begin
      if (mq.size() == 16) m_ovr = 1'b1;
      else mq.push_back(b);
    end
    uart_rx = 1'b1;
    wait_bits(1);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  exp_b;

    rst_n = 1'b0; uart_rx = 1'b1;
    bus.adr = '0; bus.dat_w = '0; bus.sel = '0; bus.we = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    m_ovr = 1'b0; m_fe = 1'b0;
    #1;
    check("reset_ack", {31'b0, bus.ack}, 32'd0);
    check("reset_dat", bus.dat_r, 32'd0);
    check("reset_irq", {31'b0, irq}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;

    rd(4'h4, d); check("reset_status", d, exp_status());
    rd(4'h8, d); check("reset_ctrl", d, 32'd0);
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC, d); check("rsvd_read", d, 32'd0);
    rd(4'h0, d); check("rxdata_empty", d, 32'd0);
    @(negedge clk); check("dat_idle_zero", bus.dat_r, 32'd0);

    // Basic reception
    wr(4'h8, 32'h1, 4'h1);
    rd(4'h8, d); check("ctrl_en", d, 32'h1);
    send_frame(8'h55, 0);
    rd(4'h4, d); check("status_one", d, 32'h0000_0101);
    rd(4'h0, d); check("rxdata_55", d, 32'h55);
    void'(mq.pop_front());
    rd(4'h4, d); check("status_after_pop", d, 32'h0);

    // Overrun: 17 random bytes back to back
    for (int unsigned i = 0; i < 17; i++) send_frame(8'($urandom), 0);
    rd(4'h4, d); check("status_full_ovr", d, exp_status());
    check("status_full_ovr_abs", d, 32'h0000_1007);
    for (int unsigned i = 0; i < 16; i++) begin
      rd(4'h0, d);
      exp_b = mq.pop_front();
      check($sformatf("fifo_order_%0d", i), d, {24'b0, exp_b});
    end
    rd(4'h0, d); check("rxdata_drained", d, 32'd0);
    wr(4'h4, 32'h4, 4'hE);
    rd(4'h4, d); check("w1c_needs_sel0", d, exp_status());
    wr(4'h4, 32'h4, 4'h1);
    m_ovr = 1'b0;
    rd(4'h4, d); check("ovr_cleared", d, exp_status());

    // Framing error, then a good frame
    send_frame(8'hA3, 2);
    rd(4'h4, d); check("fe_set", d, 32'h0000_0008);
    send_frame(8'h3C, 0);
    rd(4'h4, d); check("fe_then_good", d, 32'h0000_0109);
    rd(4'h0, d); check("rxdata_3c", d, 32'h3C);
    void'(mq.pop_front());
    wr(4'h4, 32'h8, 4'h1);
    m_fe = 1'b0;
    rd(4'h4, d); check("fe_cleared", d, 32'h0);

    // Glitch on idle line: 3 ticks low
    uart_rx = 1'b0;
    repeat (3 * 13) @(negedge clk);
    uart_rx = 1'b1;
    wait_bits(2);
    rd(4'h4, d); check("glitch_no_effect", d, 32'h0);
    b = 8'($urandom);
    send_frame(b, 0);
    rd(4'h0, d); check("after_glitch_rx", d, {24'b0, b});
    void'(mq.pop_front());

    // Enable cleared mid-frame: nothing pushed, no flags
    uart_rx = 1'b0;
    wait_bits(4);
    wr(4'h8, 32'h0, 4'h1);
    wait_bits(5);
    uart_rx = 1'b1;
    wait_bits(3);
    wr(4'h8, 32'h1, 4'h1);
    rd(4'h4, d); check("abort_no_push", d, 32'h0);

    // Interrupt
    wr(4'h8, 32'h3, 4'h1);
    @(negedge clk); check("irq_idle_low", {31'b0, irq}, 32'd0);
    b = 8'($urandom);
    uart_rx = 1'b0;
    wait_bits(1);
    for (int unsigned i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_bits(1);
    end
    uart_rx = 1'b1;
    check("irq_before_stop", {31'b0, irq}, 32'd0);
    wait_bits(1);
    mq.push_back(b);
    check("irq_after_push", {31'b0, irq}, 32'd1);
    rd(4'h0, d); check("irq_byte", d, {24'b0, b});
    void'(mq.pop_front());
    @(negedge clk); check("irq_pop_cycle", {31'b0, irq}, 32'd1);
    @(negedge clk); check("irq_fall", {31'b0, irq}, 32'd0);

    // Reset during data bit 4 with a byte pending
    send_frame(8'($urandom), 0);
    check("irq_pending", {31'b0, irq}, 32'd1);
    b = 8'($urandom);
    uart_rx = 1'b0;
    wait_bits(1);
    for (int unsigned i = 0; i < 4; i++) begin
      uart_rx = b[i];
      wait_bits(1);
    end
    uart_rx = b[4];
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_irq", {31'b0, irq}, 32'd0);
    check("midrst_ack", {31'b0, bus.ack}, 32'd0);
    check("midrst_dat", bus.dat_r, 32'd0);
    mq.delete(); m_ovr = 1'b0; m_fe = 1'b0;
    repeat (BIT / 2) @(negedge clk);
    for (int unsigned i = 5; i < 8; i++) begin
      uart_rx = b[i];
      wait_bits(1);
    end
    uart_rx = 1'b1;
    rst_n = 1'b1;
    wait_bits(1);
    rd(4'h4, d); check("postrst_status", d, 32'h0);
    rd(4'h8, d); check("postrst_ctrl", d, 32'h0);
    wr(4'h8, 32'h1, 4'h1);
    send_frame(8'h81, 0);
    rd(4'h4, d); check("postrst_status_one", d, 32'h0000_0101);
    rd(4'h0, d); check("postrst_rx_81", d, 32'h81);
    void'(mq.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
